// File: rtl/montgomery_pkg.sv
// Shared constants for the Montgomery product sequencer:
// FSM state codes, default sizes and adder operand-select codes.
package montgomery_pkg;

  localparam int N_DEF     = 512;
  localparam int CNT_W_DEF = 10;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADD_B    = 4'd1;
  localparam logic [3:0] S_ADD_M    = 4'd2;
  localparam logic [3:0] S_RES1     = 4'd3;
  localparam logic [3:0] S_SUB      = 4'd4;
  localparam logic [3:0] S_RES2     = 4'd5;
  localparam logic [3:0] S_ADD_BACK = 4'd6;
  localparam logic [3:0] S_RES3     = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [1:0] OP_ZERO  = 2'd0;
  localparam logic [1:0] OP_A     = 2'd1;
  localparam logic [1:0] OP_M     = 2'd2;
  localparam logic [1:0] OP_NEG_M = 2'd3;

endpackage

// File: rtl/montgomery_ctrl_iter.sv
// Bit-iteration counter for the Montgomery loop;
// o_last flags the final bit (i == N-1).
module mont_iter_counter
  import montgomery_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == CNT_W'(N - 1));

endmodule

// File: rtl/montgomery_ctrl.sv
// Radix-2 Montgomery product sequencer: drives an external
// accumulating adder to form A*B*2^-N mod M.
module montgomery_ctrl
  import montgomery_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = N + 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         add_clear,
  output logic         add_enable,
  output logic         add_shift,
  output logic         add_subtract,
  output logic [W-1:0] add_operand,
  input  logic [W-1:0] add_result,
  input  logic         add_lsb,
  input  logic         add_czero
);

  logic [3:0]   r_state;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_m;
  logic         r_busy;
  logic         r_done;
  logic [N-1:0] r_result;
  logic         r_clear;
  logic         r_en;
  logic         r_shift;
  logic         r_sub;
  logic [W-1:0] r_op;

  logic         w_accept;
  logic         w_last;
  logic         w_neg;
  logic [1:0]   w_sel;
  logic [W-1:0] w_m_ext;
  logic [W-1:0] w_op;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_m_ext  = W'(r_m);
  // Settled value lies in [-M, M): any set bit above N means negative.
  assign w_neg    = |add_result[W-1:N];

  mont_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_clr   (w_accept),
    .i_inc   (r_state == S_ADD_M),
    .o_last  (w_last)
  );

  always_comb begin
    w_sel = OP_ZERO;
    case (r_state)
      S_ADD_B:    w_sel = r_b[0] ? OP_A : OP_ZERO;
      S_ADD_M:    w_sel = add_lsb ? OP_M : OP_ZERO;
      S_SUB:      w_sel = OP_NEG_M;
      S_ADD_BACK: w_sel = OP_M;
      default:    w_sel = OP_ZERO;
    endcase
  end

  always_comb begin
    w_op = '0;
    case (w_sel)
      OP_A:     w_op = W'(r_a);
      OP_M:     w_op = w_m_ext;
      OP_NEG_M: w_op = ~w_m_ext + W'(1);
      default:  w_op = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_clear  <= 1'b0;
      r_en     <= 1'b0;
      r_shift  <= 1'b0;
      r_sub    <= 1'b0;
      r_op     <= '0;
    end else begin
      r_clear <= 1'b0;
      r_en    <= 1'b0;
      r_shift <= 1'b0;
      r_sub   <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= w_op;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_m     <= in_m;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ADD_B;
          end
        end
        S_ADD_B: begin
          r_en    <= 1'b1;
          r_state <= S_ADD_M;
        end
        S_ADD_M: begin
          r_en    <= 1'b1;
          r_shift <= 1'b1;
          r_b     <= r_b >> 1;
          r_state <= w_last ? S_RES1 : S_ADD_B;
        end
        S_RES1: begin
          if (add_czero) r_state <= S_SUB;
        end
        S_SUB: begin
          r_en    <= 1'b1;
          r_sub   <= 1'b1;
          r_state <= S_RES2;
        end
        S_RES2: begin
          if (add_czero) begin
            if (w_neg) begin
              r_state <= S_ADD_BACK;
            end else begin
              r_result <= add_result[N-1:0];
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_ADD_BACK: begin
          r_en    <= 1'b1;
          r_state <= S_RES3;
        end
        S_RES3: begin
          if (add_czero) begin
            r_result <= add_result[N-1:0];
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign add_clear    = r_clear;
  assign add_enable   = r_en;
  assign add_shift    = r_shift;
  assign add_subtract = r_sub;
  assign add_operand  = r_op;

endmodule

// File: tb/tb_montgomery_ctrl.sv
// Bench for montgomery_ctrl: N=8 directed vectors and N=512 random
// vectors, each DUT paired with a behavioural accumulating adder.
module tb_montgomery_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // N=8 instance
  logic       s_rstn, s_start;
  logic [7:0] s_a, s_b, s_m, s_result;
  logic       s_busy, s_done, s_clr, s_en, s_sh, s_sub, s_lsb, s_cz;
  logic [9:0] s_op, s_res, s_acc, s_sum;
  int         s_cc;

  montgomery_ctrl #(.N(8), .W(10), .CNT_W(10)) u_s (
    .clk(clk), .resetn(s_rstn), .start(s_start),
    .in_a(s_a), .in_b(s_b), .in_m(s_m),
    .busy(s_busy), .done(s_done), .result(s_result),
    .add_clear(s_clr), .add_enable(s_en), .add_shift(s_sh),
    .add_subtract(s_sub), .add_operand(s_op),
    .add_result(s_res), .add_lsb(s_lsb), .add_czero(s_cz)
  );

  assign s_sum = s_acc + s_op;
  assign s_lsb = s_acc[0] ^ (s_en & s_op[0]);
  assign s_cz  = (s_cc == 0) && !s_en && !s_clr;
  assign s_res = s_cz ? s_acc : ~s_acc;

  always @(posedge clk or negedge s_rstn) begin
    if (!s_rstn) begin
      s_acc <= '0;
      s_cc  <= 0;
    end else if (s_clr) begin
      s_acc <= '0;
      s_cc  <= 3;
    end else if (s_en) begin
      s_acc <= s_sh ? (s_sum >> 1) : s_sum;
      s_cc  <= 3;
    end else if (s_cc != 0) begin
      s_cc <= s_cc - 1;
    end
  end

  // N=512 instance
  logic         b_rstn, b_start;
  logic [511:0] b_a, b_b, b_m, b_result;
  logic         b_busy, b_done, b_clr, b_en, b_sh, b_sub, b_lsb, b_cz;
  logic [513:0] b_op, b_res, b_acc, b_sum;
  int           b_cc;

  montgomery_ctrl #(.N(512), .W(514), .CNT_W(10)) u_b (
    .clk(clk), .resetn(b_rstn), .start(b_start),
    .in_a(b_a), .in_b(b_b), .in_m(b_m),
    .busy(b_busy), .done(b_done), .result(b_result),
    .add_clear(b_clr), .add_enable(b_en), .add_shift(b_sh),
    .add_subtract(b_sub), .add_operand(b_op),
    .add_result(b_res), .add_lsb(b_lsb), .add_czero(b_cz)
  );

  assign b_sum = b_acc + b_op;
  assign b_lsb = b_acc[0] ^ (b_en & b_op[0]);
  assign b_cz  = (b_cc == 0) && !b_en && !b_clr;
  assign b_res = b_cz ? b_acc : ~b_acc;

  always @(posedge clk or negedge b_rstn) begin
    if (!b_rstn) begin
      b_acc <= '0;
      b_cc  <= 0;
    end else if (b_clr) begin
      b_acc <= '0;
      b_cc  <= 3;
    end else if (b_en) begin
      b_acc <= b_sh ? (b_sum >> 1) : b_sum;
      b_cc  <= 3;
    end else if (b_cc != 0) begin
      b_cc <= b_cc - 1;
    end
  end

  // results of the last run_s call
  logic [7:0] g_res, g_res_late;
  int         g_lat, g_ndone, g_nback;
  logic       g_busy1, g_busy_after;

  // Cycle 0 is the accepted start cycle; g_lat is the cycle done is seen.
  task automatic run_s(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] m, input int restart_at);
    bit saw_sub;
    s_a = a; s_b = b; s_m = m; s_start = 1'b1;
    g_lat = 0; g_ndone = 0; g_nback = 0; saw_sub = 0;
    g_res = '0; g_res_late = '0; g_busy1 = 0; g_busy_after = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) g_busy1 = s_busy;
      if (s_en && s_sub) saw_sub = 1;
      if (s_en && !s_sub && saw_sub) g_nback++;
      if (s_done) begin
        g_ndone++;
        if (g_lat == 0) begin
          g_lat = c;
          g_res = s_result;
        end
      end
      if (g_lat != 0 && c == g_lat + 1) g_busy_after = s_busy;
      if (g_lat != 0 && c == g_lat + 3) begin
        g_res_late = s_result;
        break;
      end
      s_start = (c + 1 == restart_at);
      @(posedge clk); #1;
    end
    s_start = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({s_busy, s_done, s_clr, s_en, s_sh, s_sub} !== 6'b0 ||
        s_op !== '0 || s_result !== '0) begin
      n_fail++;
      $display("FAIL reset_s: ctl=%b op=%h res=%h expected all 0",
               {s_busy, s_done, s_clr, s_en, s_sh, s_sub}, s_op, s_result);
    end
    n_tests++;
    if ({b_busy, b_done, b_clr, b_en, b_sh, b_sub} !== 6'b0 ||
        b_op !== '0 || b_result !== '0) begin
      n_fail++;
      $display("FAIL reset_b: ctl=%b expected 000000",
               {b_busy, b_done, b_clr, b_en, b_sh, b_sub});
    end
  endtask

  // 5*7*3 mod 13 = 1; raw accumulator ends at 1 < M, so restore runs
  task automatic test_basic();
    run_s(8'd5, 8'd7, 8'd13, 0);
    n_tests++;
    if (g_res !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_res: got %0d expected 1", g_res);
    end
    n_tests++;
    if (g_ndone !== 1 || g_lat !== 34) begin
      n_fail++;
      $display("FAIL basic_done: dones=%0d lat=%0d expected 1/34",
               g_ndone, g_lat);
    end
    n_tests++;
    if (g_nback !== 1) begin
      n_fail++;
      $display("FAIL basic_addback: got %0d expected 1", g_nback);
    end
    n_tests++;
    if (g_busy1 !== 1'b1 || g_busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: first=%b after=%b expected 1/0",
               g_busy1, g_busy_after);
    end
    n_tests++;
    if (g_res_late !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_hold: got %0d expected 1", g_res_late);
    end
  endtask

  task automatic test_final_sub();
    run_s(8'd1, 8'd1, 8'd13, 0);
    n_tests++;
    if (g_res !== 8'd3 || g_lat !== 34) begin
      n_fail++;
      $display("FAIL sub_1x1: res=%0d lat=%0d expected 3/34", g_res, g_lat);
    end
    run_s(8'd12, 8'd12, 8'd13, 0);
    n_tests++;
    if (g_res !== 8'd3 || g_lat !== 34) begin
      n_fail++;
      $display("FAIL sub_12x12: res=%0d lat=%0d expected 3/34",
               g_res, g_lat);
    end
  endtask

  // M=255: accumulator ends at 256 >= M, subtract is final (254^2 mod 255 = 1)
  task automatic test_no_restore();
    run_s(8'd254, 8'd254, 8'd255, 0);
    n_tests++;
    if (g_res !== 8'd1 || g_lat !== 28 || g_nback !== 0) begin
      n_fail++;
      $display("FAIL no_restore: res=%0d lat=%0d back=%0d expected 1/28/0",
               g_res, g_lat, g_nback);
    end
  endtask

  task automatic test_zero();
    run_s(8'd0, 8'd9, 8'd13, 0);
    n_tests++;
    if (g_res !== 8'd0 || g_nback !== 1 || g_lat !== 34) begin
      n_fail++;
      $display("FAIL zero_a: res=%0d back=%0d lat=%0d expected 0/1/34",
               g_res, g_nback, g_lat);
    end
    run_s(8'd9, 8'd0, 8'd13, 0);
    n_tests++;
    if (g_res !== 8'd0 || g_nback !== 1 || g_lat !== 34) begin
      n_fail++;
      $display("FAIL zero_b: res=%0d back=%0d lat=%0d expected 0/1/34",
               g_res, g_nback, g_lat);
    end
  endtask

  task automatic test_restart();
    run_s(8'd5, 8'd7, 8'd13, 5);
    n_tests++;
    if (g_res !== 8'd1 || g_ndone !== 1 || g_lat !== 34) begin
      n_fail++;
      $display("FAIL restart_mid: res=%0d dones=%0d lat=%0d expected 1/1/34",
               g_res, g_ndone, g_lat);
    end
    run_s(8'd5, 8'd7, 8'd13, 34);
    n_tests++;
    if (g_ndone !== 1 || g_busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL start_at_done: dones=%0d busy=%b expected 1/0",
               g_ndone, g_busy_after);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    s_a = 8'd5; s_b = 8'd7; s_m = 8'd13; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    s_rstn = 1'b0;
    #1;
    n_tests++;
    if ({s_busy, s_done, s_clr, s_en, s_sh, s_sub} !== 6'b0 ||
        s_op !== '0 || s_result !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: ctl=%b op=%h res=%h expected all 0",
               {s_busy, s_done, s_clr, s_en, s_sh, s_sub}, s_op, s_result);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({s_busy, s_done, s_en} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: busy/done/en=%b expected 000",
               {s_busy, s_done, s_en});
    end
    @(negedge clk);
    s_rstn = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s_done) nd++;
    end
    n_tests++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d dones expected 0", nd);
    end
    run_s(8'd5, 8'd7, 8'd13, 0);
    n_tests++;
    if (g_res !== 8'd1 || g_ndone !== 1) begin
      n_fail++;
      $display("FAIL reset_rerun: res=%0d dones=%0d expected 1/1",
               g_res, g_ndone);
    end
  endtask

  // Check r*2^512 == A*B (mod M) and r < M with wide arithmetic
  task automatic test_big();
    logic [511:0]  a, b, m, t1, t2;
    logic [1023:0] lhs, rhs;
    bit got, saw, back;
    int n_back, n_nob;
    n_back = 0; n_nob = 0;
    for (int v = 0; v < 40; v++) begin
      for (int k = 0; k < 16; k++) begin
        m[k*32 +: 32]  = $urandom;
        t1[k*32 +: 32] = $urandom;
        t2[k*32 +: 32] = $urandom;
      end
      m[511] = 1'b1;
      m[0]   = 1'b1;
      a = t1 % m;
      b = t2 % m;
      b_a = a; b_b = b; b_m = m; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      b_a = ~a; b_b = ~b; b_m = '0;
      got = 0; saw = 0; back = 0;
      for (int c = 1; c < 1500 && !got; c++) begin
        if (b_en && b_sub) saw = 1;
        if (b_en && !b_sub && saw) back = 1;
        if (b_done) got = 1;
        else begin
          @(posedge clk); #1;
        end
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL big_timeout[%0d]: no done within 1500 cycles", v);
      end else begin
        lhs = {b_result, 512'b0} % {512'b0, m};
        rhs = ({512'b0, a} * {512'b0, b}) % {512'b0, m};
        if (lhs !== rhs || b_result >= m) begin
          n_fail++;
          $display("FAIL big_mont[%0d]: r*R mod M=%h required A*B mod M=%h",
                   v, lhs[511:0], rhs[511:0]);
        end
      end
      if (back) n_back++;
      else n_nob++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (n_back == 0) begin
      n_fail++;
      $display("FAIL big_restore_path: got %0d required >0", n_back);
    end
    n_tests++;
    if (n_nob == 0) begin
      n_fail++;
      $display("FAIL big_direct_path: got %0d required >0", n_nob);
    end
  endtask

  initial begin
    s_rstn = 1'b0; b_rstn = 1'b0;
    s_start = 1'b0; b_start = 1'b0;
    s_a = '0; s_b = '0; s_m = '0;
    b_a = '0; b_b = '0; b_m = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    s_rstn = 1'b1; b_rstn = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_final_sub();
    test_no_restore();
    test_zero();
    test_restart();
    test_reset_mid();
    test_big();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
